// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the period and high time of an external PWM input, in clk cycles.
// This is the receive-side partner of the PWM generator in the timer
// peripheral. The register block reads the results. Feeding the generator
// output back into pwm_in gives a loopback self-test.
//
// Optional feature macro: PWM_CAP_FILTER_EN
//   When defined, a glitch filter sits between the synchronizer and the
//   edge detector. The filtered level follows the synchronized input only
//   after FILTER_LEN consecutive samples disagree with it. This adds
//   FILTER_LEN clk of edge latency. Both edges are delayed equally, so the
//   period measurement does not change.
//   When undefined, edges come straight from the synchronized input.
//
// Parameters
//   CNT_W        width of the period/high counters and result registers
//   SYNC_STAGES  synchronizer depth on pwm_in (>= 2)
//   FILTER_LEN   consecutive equal samples the glitch filter needs
//
// Ports
//   clk          peripheral clock
//   rst_n        synchronous active-low reset
//   cap_en       capture enable; 0 forces IDLE, clears counters and ovf
//   ovf_clr      single-cycle pulse that clears the sticky ovf flag
//   pwm_in       asynchronous PWM input
//   meas_period  cycles between the last two rising edges
//   meas_high    high cycles within that period
//   meas_valid   1-cycle pulse: meas_* were loaded this cycle
//   ovf          sticky timeout flag (no rising edge for 2^CNT_W-1 cycles)
//   busy         1 whenever the FSM is not in IDLE
//
// Handshake: there is no back-pressure. meas_valid pulses for exactly one
// cycle. meas_period and meas_high stay stable from that pulse until the
// next one, so a reader can pick them up at any time in between.
//
// The FSM state is held in the internal signal 'state' (type state_t).
// Checkers can bind to it for observation.
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             ovf_clr,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             ovf,
  output logic             busy
);

  // Reject parameter values the structure below cannot support.
  generate
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
      $error("pwm_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic             s_sync;   // synchronized level
  logic             s_lvl;    // level seen by the edge detector
  logic             s_d;
  logic             rise;
  logic             fall;

  logic [CNT_W-1:0] cnt_per;
  logic [CNT_W-1:0] cnt_hi;
  logic             cnt_full;

  // Datapath controls, produced by the FSM output process.
  logic             cnt_clr;
  logic             cnt_start;
  logic             per_inc;
  logic             hi_inc;
  logic             load_meas;
  logic             set_ovf;

  // -------------------------------------------------------------------------
  // Input synchronizer. Bit 0 takes the raw pin. The top bit is the
  // synchronized level.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
  // -------------------------------------------------------------------------
  // Glitch filter. filt_cnt counts consecutive synchronized samples that
  // differ from the current filtered level. On the FILTER_LEN-th such sample
  // the level flips. Any sample that agrees with the level restarts the
  // count, so pulses shorter than FILTER_LEN clk never reach the edge
  // detector.
  // -------------------------------------------------------------------------
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] filt_cnt;
  logic           filt_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_cnt   <= '0;
      filt_level <= 1'b0;
    end else if (s_sync != filt_level) begin
      if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_level <= s_sync;
        filt_cnt   <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign s_lvl = filt_level;
`else
  assign s_lvl = s_sync;
`endif

  // -------------------------------------------------------------------------
  // Edge detector
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s_lvl;
    end
  end

  assign rise     = s_lvl & ~s_d;
  assign fall     = ~s_lvl & s_d;
  assign cnt_full = (cnt_per == '1);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. Dropping cap_en overrides everything else.
  // A timeout (period counter saturated with no rise this cycle) goes back
  // to ARM, so the next measurement again needs two rising edges.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!cap_en) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_ARM;
        ST_ARM: begin
          if (rise) state_nxt = ST_HIGH;
        end
        ST_HIGH: begin
          if (cnt_full && !rise) state_nxt = ST_ARM;
          else if (fall)         state_nxt = ST_LOW;
        end
        ST_LOW: begin
          if (rise)          state_nxt = ST_HIGH;
          else if (cnt_full) state_nxt = ST_ARM;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and datapath controls.
  // The rising-edge cycle is counted as the first cycle of both the period
  // and the high phase, so counters restart at 1. The falling-edge cycle
  // counts toward the period but not the high time. This gives period = H+L
  // and high = H.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_start = 1'b0;
    per_inc   = 1'b0;
    hi_inc    = 1'b0;
    load_meas = 1'b0;
    set_ovf   = 1'b0;
    busy      = (state != ST_IDLE);
    if (!cap_en) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: cnt_clr = 1'b1;
        ST_ARM: begin
          // Any partial cycle seen before the first rise is discarded.
          if (rise) cnt_start = 1'b1;
          else      cnt_clr   = 1'b1;
        end
        ST_HIGH: begin
          if (cnt_full && !rise) begin
            set_ovf = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            per_inc = 1'b1;
            hi_inc  = ~fall;
          end
        end
        ST_LOW: begin
          if (rise) begin
            load_meas = 1'b1;
            cnt_start = 1'b1;
          end else if (cnt_full) begin
            set_ovf = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            per_inc = 1'b1;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Period / high counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_per <= '0;
      cnt_hi  <= '0;
    end else if (cnt_clr) begin
      cnt_per <= '0;
      cnt_hi  <= '0;
    end else if (cnt_start) begin
      cnt_per <= CNT_ONE;
      cnt_hi  <= CNT_ONE;
    end else begin
      if (per_inc) cnt_per <= cnt_per + CNT_ONE;
      if (hi_inc)  cnt_hi  <= cnt_hi + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Result registers. They keep their values across cap_en drops and
  // timeouts. Only reset or a new completed period changes them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
    end else begin
      meas_valid <= load_meas;
      if (load_meas) begin
        meas_period <= cnt_per;
        meas_high   <= cnt_hi;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky overflow flag. If a set and a clear arrive in the same cycle,
  // the set wins so that no timeout is lost. set_ovf can only be asserted
  // while cap_en is 1.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (set_ovf) begin
      ovf <= 1'b1;
    end else if (ovf_clr || !cap_en) begin
      ovf <= 1'b0;
    end
  end

endmodule
